// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RISC-V memory store path.
// Contents:
//   FUNC3_SB / FUNC3_SH / FUNC3_SW  store func3 encodings
//   store_state_e                   store FSM states (IDLE, BEAT0, BEAT1)
//   MASK_B / MASK_H / MASK_W        byte-enable patterns at lane offset 0
package riscv_mem_pkg;

  localparam logic [2:0] FUNC3_SB = 3'b000;
  localparam logic [2:0] FUNC3_SH = 3'b001;
  localparam logic [2:0] FUNC3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } store_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_store_unit_if.sv
// Bus bundle for mem_store_unit.
// Signals:
//   req_valid/req_ready           store request handshake
//   req_addr/req_data/req_func3   byte address, rs2 value, store func3
//   mem_valid/mem_ready           memory write beat handshake
//   mem_addr/mem_wdata/mem_we     word-aligned address, lane data, byte enables
//   store_err                     one-cycle rejection pulse
// Modports: master = request producer / memory side, slave = the store unit.
interface mem_store_unit_if #(
  parameter int WIDTH  = 32,
  parameter int NBYTES = WIDTH / 8
);
  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  req_addr;
  logic [WIDTH-1:0]  req_data;
  logic [2:0]        req_func3;
  logic              mem_valid;
  logic              mem_ready;
  logic [WIDTH-1:0]  mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [NBYTES-1:0] mem_we;
  logic              store_err;

  modport master (
    output req_valid, req_addr, req_data, req_func3, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_we, store_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_func3, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_we, store_err
  );
endinterface

// File: rtl/store_lane_align.sv
// Combinational lane alignment for stores.
// Ports:
//   off        in   byte offset within the word (addr[1:0])
//   func3      in   store func3
//   data       in   rs2 value
//   wide_data  out  2*WIDTH data: replicated lanes for aligned stores,
//                   {0,data} << 8*off for misaligned SH/SW
//   mask       out  2*NBYTES byte mask, base_mask << off
//   misaligned out  SH with odd offset or SW with nonzero offset
//   illegal    out  func3 is not SB/SH/SW
module store_lane_align
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NBYTES = WIDTH / 8
) (
  input  logic [1:0]          off,
  input  logic [2:0]          func3,
  input  logic [WIDTH-1:0]    data,
  output logic [2*WIDTH-1:0]  wide_data,
  output logic [2*NBYTES-1:0] mask,
  output logic                misaligned,
  output logic                illegal
);

  logic [NBYTES-1:0] base_mask;
  logic [WIDTH-1:0]  repl;
  logic [4:0]        shamt;

  always_comb begin
    base_mask = '0;
    repl      = data;
    shamt     = {off, 3'b000};
    illegal   = func3[2] | (func3[1:0] == 2'b11);

    case (func3)
      FUNC3_SB: begin
        base_mask = MASK_B;
        repl      = {4{data[7:0]}};
      end
      FUNC3_SH: begin
        base_mask = MASK_H;
        repl      = {2{data[15:0]}};
      end
      FUNC3_SW: begin
        base_mask = MASK_W;
        repl      = data;
      end
      default: begin
        base_mask = '0;
        repl      = data;
      end
    endcase

    misaligned = ((func3 == FUNC3_SH) && off[0]) ||
                 ((func3 == FUNC3_SW) && (off != 2'b00));

    mask = {{NBYTES{1'b0}}, base_mask} << off;

    // Aligned stores keep the lane-replicated form; only a misaligned
    // access needs the true shift that can spill into the upper word.
    if (misaligned) begin
      wide_data = {{WIDTH{1'b0}}, data} << shamt;
    end else begin
      wide_data = {{WIDTH{1'b0}}, repl};
    end
  end

endmodule

// File: rtl/mem_store_unit.sv
// RISC-V store unit: turns SB/SH/SW requests into word-aligned memory write
// beats with lane-replicated data and byte write-enables, through one output
// register stage with valid/ready backpressure.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of mem_store_unit_if (request and memory sides)
// Optional build macro: MISALIGNED_SPLIT_EN splits misaligned SH/SW into two
// beats (aligned word, then address+4) instead of rejecting them.
module mem_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NBYTES = WIDTH / 8
) (
  input  logic clk,
  input  logic rst,
  mem_store_unit_if.slave bus
);

  store_state_e state, next_state;

  logic [2*WIDTH-1:0]  wide_data;
  logic [2*NBYTES-1:0] mask;
  logic                misaligned;
  logic                illegal;
  logic                reject;
  logic                ready;
  logic                accept;
  logic                take;
  logic                load_beat1;
  logic                beat1_pend;

  logic [WIDTH-1:0]    addr_p1;
  logic [WIDTH-1:0]    wdata_p1;
  logic [NBYTES-1:0]   we_p1;
  logic                err_p1;

  store_lane_align #(.WIDTH(WIDTH), .NBYTES(NBYTES)) u_align (
    .off       (bus.req_addr[1:0]),
    .func3     (bus.req_func3),
    .data      (bus.req_data),
    .wide_data (wide_data),
    .mask      (mask),
    .misaligned(misaligned),
    .illegal   (illegal)
  );

`ifdef MISALIGNED_SPLIT_EN
  logic [WIDTH-1:0]  beat1_wdata;
  logic [NBYTES-1:0] beat1_we;

  assign reject = illegal;

  // Upper half of a split store, parked until BEAT0 drains. An empty
  // upper mask (e.g. SH at offset 1) means no second beat is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat1_pend  <= 1'b0;
      beat1_wdata <= '0;
      beat1_we    <= '0;
    end else if (take) begin
      beat1_pend  <= misaligned && (mask[2*NBYTES-1:NBYTES] != '0);
      beat1_wdata <= wide_data[2*WIDTH-1:WIDTH];
      beat1_we    <= mask[2*NBYTES-1:NBYTES];
    end else if (load_beat1) begin
      beat1_pend  <= 1'b0;
    end
  end
`else
  logic unused_split;

  assign reject       = illegal | misaligned;
  assign beat1_pend   = 1'b0;
  assign unused_split = ^{wide_data[2*WIDTH-1:WIDTH], mask[2*NBYTES-1:NBYTES]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    load_beat1 = 1'b0;

    // Ready in the final beat lets a new store load with no bubble.
    case (state)
      IDLE:    ready = 1'b1;
      BEAT0:   ready = bus.mem_ready && !beat1_pend;
      BEAT1:   ready = bus.mem_ready;
      default: ready = 1'b0;
    endcase

    accept = bus.req_valid && ready;
    take   = accept && !reject;

    case (state)
      IDLE: begin
        if (take) next_state = BEAT0;
      end
      BEAT0: begin
        if (bus.mem_ready) begin
          if (beat1_pend) begin
            next_state = BEAT1;
            load_beat1 = 1'b1;
          end else begin
            next_state = take ? BEAT0 : IDLE;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ready) next_state = take ? BEAT0 : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output register stage (p1): held whenever neither a new store nor the
  // second half of a split is being loaded, which covers the stall case.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
      we_p1    <= '0;
      err_p1   <= 1'b0;
    end else begin
      err_p1 <= accept && reject;
      if (take) begin
        addr_p1  <= {bus.req_addr[WIDTH-1:2], 2'b00};
        wdata_p1 <= wide_data[WIDTH-1:0];
        we_p1    <= mask[NBYTES-1:0];
`ifdef MISALIGNED_SPLIT_EN
      end else if (load_beat1) begin
        addr_p1  <= addr_p1 + WIDTH'(4);
        wdata_p1 <= beat1_wdata;
        we_p1    <= beat1_we;
`endif
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.mem_valid = (state != IDLE);
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;
  assign bus.mem_we    = we_p1;
  assign bus.store_err = err_p1;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: a table of single-store vectors
// followed by hand-written multi-cycle sequences (stall, back-to-back,
// error-then-store, reset mid-beat, and split stores when
// MISALIGNED_SPLIT_EN is defined).
module tb_mem_store_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_store_unit_if #(.WIDTH(32)) bus ();

  mem_store_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  we;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
                              logic ev, logic [31:0] ea, logic [31:0] ew,
                              logic [3:0] we, logic err);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.data = data; v.ev = ev;
    v.ea = ea; v.ew = ew; v.we = we; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_data  = data;
  endtask

  task automatic chk_beat(input string name, input logic [31:0] ea,
                          input logic [31:0] ew, input logic [3:0] we);
    chk({name, ".valid"}, 32'(bus.mem_valid), 32'd1);
    chk({name, ".addr"},  bus.mem_addr, ea);
    chk({name, ".wdata"}, bus.mem_wdata, ew);
    chk({name, ".we"},    32'(bus.mem_we), 32'(we));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_func3 = '0;
    bus.mem_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst.valid", 32'(bus.mem_valid), 32'd0);
    chk("rst.addr",  bus.mem_addr, 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    chk("rst.we",    32'(bus.mem_we), 32'd0);
    chk("rst.err",   32'(bus.store_err), 32'd0);
    chk("rst.ready", 32'(bus.req_ready), 32'd1);

    // Single-store vectors: f3, addr, data, valid, addr, wdata, we, err
    vecs.push_back(mk(3'b000, 32'h0000_1003, 32'hDEAD_BEEF, 1'b1, 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000, 1'b0));
    vecs.push_back(mk(3'b000, 32'h0000_1000, 32'h0000_00A5, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0001, 1'b0));
    vecs.push_back(mk(3'b000, 32'h0000_1002, 32'h1234_5678, 1'b1, 32'h0000_1000, 32'h7878_7878, 4'b0100, 1'b0));
    vecs.push_back(mk(3'b001, 32'h0000_2002, 32'h0000_CAFE, 1'b1, 32'h0000_2000, 32'hCAFE_CAFE, 4'b1100, 1'b0));
    vecs.push_back(mk(3'b001, 32'h0000_2000, 32'hFFFF_1234, 1'b1, 32'h0000_2000, 32'h1234_1234, 4'b0011, 1'b0));
    vecs.push_back(mk(3'b010, 32'h0000_3008, 32'h1122_3344, 1'b1, 32'h0000_3008, 32'h1122_3344, 4'b1111, 1'b0));
    vecs.push_back(mk(3'b011, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1));
    vecs.push_back(mk(3'b100, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1));
    vecs.push_back(mk(3'b110, 32'h0000_0008, 32'h3333_3333, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1));
`ifndef MISALIGNED_SPLIT_EN
    vecs.push_back(mk(3'b010, 32'h0000_0003, 32'h4444_4444, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1));
    vecs.push_back(mk(3'b001, 32'h0000_2001, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      bus.mem_ready = 1'b1;
      drive(vecs[i].f3, vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d.req_ready", i), 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 1'b0;
      chk($sformatf("v%0d.valid", i), 32'(bus.mem_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.err", i),   32'(bus.store_err), 32'(vecs[i].err));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d.addr", i),  bus.mem_addr, vecs[i].ea);
        chk($sformatf("v%0d.wdata", i), bus.mem_wdata, vecs[i].ew);
        chk($sformatf("v%0d.we", i),    32'(bus.mem_we), 32'(vecs[i].we));
      end
      tick();
      chk($sformatf("v%0d.drain_valid", i), 32'(bus.mem_valid), 32'd0);
      chk($sformatf("v%0d.err_once", i),    32'(bus.store_err), 32'd0);
    end

    // SH with memory stalled for three cycles
    bus.mem_ready = 1'b0;
    drive(3'b001, 32'h0000_2002, 32'h0000_CAFE);
    tick();
    bus.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_beat($sformatf("stall%0d", c), 32'h0000_2000, 32'hCAFE_CAFE, 4'b1100);
      chk($sformatf("stall%0d.req_ready", c), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("stall.release_ready", 32'(bus.req_ready), 32'd1);
    chk_beat("stall.release", 32'h0000_2000, 32'hCAFE_CAFE, 4'b1100);
    tick();
    chk("stall.done_valid", 32'(bus.mem_valid), 32'd0);

    // Four back-to-back SW with no bubbles
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(3'b010, 32'(4 * k), 32'hA000_0000 + 32'(k));
      #1;
      chk($sformatf("b2b%0d.req_ready", k), 32'(bus.req_ready), 32'd1);
      tick();
      chk_beat($sformatf("b2b%0d", k), 32'(4 * k), 32'hA000_0000 + 32'(k), 4'b1111);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b.done_valid", 32'(bus.mem_valid), 32'd0);

    // Rejected request immediately followed by a good store
    drive(3'b011, 32'h0000_0010, 32'h0);
    tick();
    chk("rej.err",   32'(bus.store_err), 32'd1);
    chk("rej.valid", 32'(bus.mem_valid), 32'd0);
    drive(3'b000, 32'h0000_0010, 32'h0000_005A);
    tick();
    bus.req_valid = 1'b0;
    chk("rej.next_err", 32'(bus.store_err), 32'd0);
    chk_beat("rej.next", 32'h0000_0010, 32'h5A5A_5A5A, 4'b0001);
    tick();

`ifdef MISALIGNED_SPLIT_EN
    // Misaligned SW split into two beats
    drive(3'b010, 32'h0000_0101, 32'h1122_3344);
    tick();
    bus.req_valid = 1'b0;
    chk_beat("split.b0", 32'h0000_0100, 32'h2233_4400, 4'b1110);
    chk("split.b0_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk_beat("split.b1", 32'h0000_0104, 32'h0000_0011, 4'b0001);
    chk("split.b1_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("split.done_valid", 32'(bus.mem_valid), 32'd0);

    // Address wrap on the second beat
    drive(3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    tick();
    bus.req_valid = 1'b0;
    chk_beat("wrap.b0", 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100);
    tick();
    chk_beat("wrap.b1", 32'h0000_0000, 32'h0000_AABB, 4'b0011);
    tick();
    chk("wrap.done_valid", 32'(bus.mem_valid), 32'd0);

    // Misaligned SH that fits in one word: no second beat
    drive(3'b001, 32'h0000_0101, 32'h0000_BEEF);
    tick();
    bus.req_valid = 1'b0;
    chk_beat("sh1.b0", 32'h0000_0100, 32'h00BE_EF00, 4'b0110);
    chk("sh1.err", 32'(bus.store_err), 32'd0);
    tick();
    chk("sh1.done_valid", 32'(bus.mem_valid), 32'd0);
`endif

    // Reset while a beat is stalled
    bus.mem_ready = 1'b0;
    drive(3'b010, 32'h0000_0040, 32'h5566_7788);
    tick();
    bus.req_valid = 1'b0;
    chk("rstmid.pre_valid", 32'(bus.mem_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.valid", 32'(bus.mem_valid), 32'd0);
    chk("rstmid.we",    32'(bus.mem_we), 32'd0);
    chk("rstmid.ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("rstmid.stay_idle", 32'(bus.mem_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Store-side counterpart of the load mask/extend path.
- Accepts one RISC-V store per handshake (SB/SH/SW plus byte address) and emits a word-aligned memory write with byte lanes replicated and byte write-enables.
- Sits between the MEM stage and the data memory / MMIO write port.
- One output register stage with a valid/ready handshake, so memory backpressure stalls the pipeline cleanly.

Parameters:
- WIDTH, 32, data and address width in bits; only 32 is supported.
- NBYTES, WIDTH/8, number of byte lanes and write-enable bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_addr  in  WIDTH  byte address of the store.
- req_data  in  WIDTH  rs2 value; low byte/half used for SB/SH.
- req_func3  in  3  RISC-V store func3: 000 SB, 001 SH, 010 SW.
- mem_valid  out  1  write beat present.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  WIDTH  word-aligned address; bits [1:0] always 0.
- mem_wdata  out  WIDTH  lane-positioned write data.
- mem_we  out  NBYTES  per-byte write enables.
- store_err  out  1  one-cycle pulse: request rejected (illegal func3 or misaligned).

Behaviour:
- Reset: mem_valid=0, mem_addr=0, mem_wdata=0, mem_we=0, store_err=0, state IDLE. Reset mid-beat drops the pending write with no partial output.
- States and transitions:
  - IDLE: req_ready=1.
  - BEAT0: mem_valid=1.
  - BEAT1: mem_valid=1; exists only with the optional feature.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - The accepted beat appears on mem_* the next cycle (latency 1).
  - mem_* are held stable while mem_valid && !mem_ready.
  - req_ready=1 in IDLE, or in the final beat when mem_ready=1 (back-to-back stores, one per cycle with no bubble).
- Byte offset: off = req_addr[1:0].
  - SB: we = 0001<<off; wdata = {4{data[7:0]}}.
  - SH: we = 0011<<off; wdata = {2{data[15:0]}}.
  - SW: we = 1111; wdata = data.
  - mem_addr = {req_addr[WIDTH-1:2], 2'b00}.
- Misaligned means SH with off[0]=1, or SW with off!=0.
- Illegal func3 means func3[2]=1 or func3[1:0]=11.
- Rejected request (misaligned or illegal):
  - Still accepted (consumes the handshake).
  - No beat issued; state stays IDLE.
  - store_err=1 on the next cycle only.
- Simultaneous final-beat completion and new accept: the new beat loads directly, with no IDLE cycle.
- Error pulse and new accept: store_err and a new beat may be asserted together only from separate requests in consecutive cycles.

Optional Feature:
- MISALIGNED_SPLIT_EN defined: misaligned SH/SW are split instead of rejected.
  - Form a 2*WIDTH shifted value ({0,data}<<8*off) and an 8-bit mask (base_mask<<off).
  - BEAT0: low word and low 4 mask bits at the aligned address.
  - BEAT1: high word and high 4 mask bits at address+4.
  - Address+4 wraps modulo 2^WIDTH.
  - BEAT1 is skipped if its mask is 0.
  - Illegal func3 still raises store_err.
- MISALIGNED_SPLIT_EN undefined: BEAT1 and the split logic are absent; misaligned stores raise store_err.

Decomposition:
- Shared package riscv_mem_pkg:
  - FUNC3_SB/SH/SW constants.
  - Store-state enum (IDLE/BEAT0/BEAT1).
  - Base mask constants (MASK_B=0001, MASK_H=0011, MASK_W=1111).
- One natural sub-module, store_lane_align: combinational offset, func3 and data in; shifted 2*WIDTH data, 8-bit mask and misaligned/illegal flags out. The FSM and output register stay in mem_store_unit.

Test Plan:
- SB, addr=0x1003, data=0xDEADBEEF -> next cycle mem_addr=0x1000, we=1000, wdata=0xEFEFEFEF, mem_valid=1.
- SH, addr=0x2002, data=0x0000CAFE, mem_ready held 0 for 3 cycles -> outputs stable throughout (we=1100, wdata=0xCAFECAFE); req_ready=0 until the cycle mem_ready=1.
- Four back-to-back SW at 0x0,0x4,0x8,0xC, mem_ready=1 -> four consecutive beats, we=1111, no bubbles, req_ready constantly 1.
- SW at 0x3 without the macro -> no mem_valid; store_err=1 for exactly one cycle. func3=011 -> same.
- With MISALIGNED_SPLIT_EN, SW addr=0x101, data=0x11223344 -> beat0 addr 0x100, we=1110, wdata=0x22334400; beat1 addr 0x104, we=0001, wdata=0x00000011. At addr=0xFFFFFFFE, SW beat1 addr=0x00000000.
- rst asserted while in BEAT0 with mem_ready=0 -> next cycle mem_valid=0, we=0, req_ready=1.
